// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port word RAM: data stage over fetch, with
// starvation relief for fetch and read-modify-write emulation of partial stores.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_ready,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_W-1:0]     dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  input  logic [DATA_W/8-1:0]   dm_be,
  output logic                  dm_ready,
  output logic                  dm_rvalid,
  output logic [DATA_W-1:0]     dm_rdata,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic {ARB, RMW} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  starve_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;

  logic if_grant, dm_load, rmw_start;

  // NOTE: every signal gets a default at the top of always_comb so that no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nxt = state;
    if_ready  = 1'b0;
    dm_ready  = 1'b0;
    if_grant  = 1'b0;
    dm_load   = 1'b0;
    rmw_start = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;

    if (!reset) begin
      unique case (state)
        ARB: begin
          if (dm_req && (starve_cnt < STARVE_LIM)) begin
            dm_ready = 1'b1;
            if (!dm_we) begin
              dm_load  = 1'b1;
              ram_addr = dm_addr;
            end else if (&dm_be) begin
              ram_we    = 1'b1;
              ram_addr  = dm_addr;
              ram_wdata = dm_wdata;
            end else if (|dm_be) begin
              // Partial store: read the old word now, merge and write it next cycle.
              rmw_start = 1'b1;
              ram_addr  = dm_addr;
              state_nxt = RMW;
            end
            // be == 0 store: accepted as a no-op, port left idle.
          end else if (if_req) begin
            if_ready = 1'b1;
            if_grant = 1'b1;
            ram_addr = if_addr;
          end
        end
        RMW: begin
          ram_we   = 1'b1;
          ram_addr = lat_addr;
          for (int i = 0; i < BE_W; i++) begin
            ram_wdata[8*i +: 8] = lat_be[i] ? lat_wdata[8*i +: 8] : ram_rdata[8*i +: 8];
          end
          state_nxt = ARB;
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge, independent of block order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ARB;
      starve_cnt <= '0;
      if_rvalid  <= 1'b0;
      dm_rvalid  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
    end else begin
      state     <= state_nxt;
      if_rvalid <= if_grant;
      dm_rvalid <= dm_load;
      if (rmw_start) begin
        lat_addr  <= dm_addr;
        lat_wdata <= dm_wdata;
        lat_be    <= dm_be;
      end
      // Counts every cycle fetch waits, RMW cycles included.
      if (!if_req || if_grant) begin
        starve_cnt <= '0;
      end else if (starve_cnt < STARVE_LIM) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign if_rdata = ram_rdata;
  assign dm_rdata = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM
// (synchronous write, registered read-first output).
module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              if_req, if_ready, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req, dm_we, dm_ready, dm_rvalid;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata, dm_rdata;
  logic [3:0]        dm_be;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one cycle; inputs change and outputs are sampled mid-low-phase.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic dm_drive(input logic we, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d; dm_be = be;
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b1; if_addr = 16'h0010;
    dm_drive(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);

    // Reset held two cycles with both requesters active.
    @(negedge clock); #1;
    check("rst_if_ready", {31'b0, if_ready}, 0);
    check("rst_dm_ready", {31'b0, dm_ready}, 0);
    check("rst_ram_we",   {31'b0, ram_we}, 0);
    step(); #1;
    check("rst_rvalid", {30'b0, if_rvalid, dm_rvalid}, 0);
    check("rst_ram_we2", {31'b0, ram_we}, 0);

    // Release: DM wins first; its full-word store preloads 0x0010.
    reset = 1'b0; #1;
    check("post_rst_dm_first", {30'b0, dm_ready, if_ready}, 32'h2);
    check("post_rst_we", {31'b0, ram_we}, 1);
    check("post_rst_addr", {16'b0, ram_addr}, 32'h0010);
    step();

    // IF read alone.
    dm_req = 1'b0; #1;
    check("if_ready", {31'b0, if_ready}, 1);
    check("if_addr_out", {16'b0, ram_addr}, 32'h0010);
    step();
    dm_drive(1'b0, 16'h0010, 32'h0, 4'h0); if_req = 1'b0; #1;
    check("if_rvalid", {30'b0, if_rvalid, dm_rvalid}, 32'h2);
    check("if_rdata", if_rdata, 32'hDEADBEEF);
    check("dm_load_ready", {31'b0, dm_ready}, 1);
    check("dm_load_we", {31'b0, ram_we}, 0);
    step();
    dm_drive(1'b1, 16'h0020, 32'h11223344, 4'hF); #1;
    check("dm_rvalid", {30'b0, if_rvalid, dm_rvalid}, 32'h1);
    check("dm_rdata", dm_rdata, 32'hDEADBEEF);
    step();

    // Partial store RMW with IF contending.
    dm_drive(1'b1, 16'h0020, 32'hAABBCCDD, 4'b0101);
    if_req = 1'b1; if_addr = 16'h0040; #1;
    check("rmw_t_ready", {30'b0, dm_ready, if_ready}, 32'h2);
    check("rmw_t_we", {31'b0, ram_we}, 0);
    step();
    dm_req = 1'b0; #1;
    check("rmw_t1_ready", {30'b0, dm_ready, if_ready}, 0);
    check("rmw_t1_we", {31'b0, ram_we}, 1);
    check("rmw_t1_addr", {16'b0, ram_addr}, 32'h0020);
    check("rmw_t1_wdata", ram_wdata, 32'h11BB33DD);
    step();
    check("rmw_mem", mem[16'h0020], 32'h11BB33DD);
    check("rmw_if_after", {31'b0, if_ready}, 1);
    step();

    // Starvation: IF wins on the 5th contending cycle, then DM again.
    dm_drive(1'b1, 16'h0050, 32'h0BAD0001, 4'hF); if_addr = 16'h0060;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check($sformatf("starve_dm_%0d", i), {30'b0, dm_ready, if_ready}, 32'h2);
      step();
    end
    #1;
    check("starve_if_wins", {30'b0, dm_ready, if_ready}, 32'h1);
    check("starve_if_addr", {16'b0, ram_addr}, 32'h0060);
    step(); #1;
    check("starve_dm_next", {30'b0, dm_ready, if_ready}, 32'h2);
    step();
    if_req = 1'b0;

    // Read-after-write, then a be=0 no-op store.
    dm_drive(1'b1, 16'h0030, 32'hCAFEF00D, 4'hF); step();
    dm_drive(1'b0, 16'h0030, 32'h0, 4'h0); step();
    if_req = 1'b1; if_addr = 16'h0070;
    dm_drive(1'b1, 16'h0030, 32'h12345678, 4'h0); #1;
    check("raw_rdata", dm_rdata, 32'hCAFEF00D);
    check("noop_ready", {30'b0, dm_ready, if_ready}, 32'h2);
    check("noop_we", {31'b0, ram_we}, 0);
    step();
    dm_req = 1'b0; if_req = 1'b0; #1;
    check("noop_mem", mem[16'h0030], 32'hCAFEF00D);
    check("noop_no_rvalid", {31'b0, dm_rvalid}, 0);
    step();

    // Reset in the RMW cycle aborts the write.
    dm_drive(1'b1, 16'h0020, 32'h99999999, 4'b0001); #1;
    check("rst_rmw_grant", {31'b0, dm_ready}, 1);
    step();
    dm_req = 1'b0; reset = 1'b1; #1;
    check("rst_rmw_we", {31'b0, ram_we}, 0);
    step();
    reset = 1'b0; if_req = 1'b1; if_addr = 16'h0020; #1;
    check("rst_rmw_mem", mem[16'h0020], 32'h11BB33DD);
    check("rst_rmw_arb", {31'b0, if_ready}, 1);
    step();
    if_req = 1'b0; #1;
    check("rst_rmw_if_rdata", if_rdata, 32'h11BB33DD);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port, word-addressed 32-bit data RAM between two requesters: instruction fetch (IF, read-only) and the data-memory stage (DM, read/write).
- Issues at most one RAM access per cycle. DM has priority over IF; an anti-starvation counter guarantees IF progress.
- The RAM has no byte enables, so partial stores are done as a read-modify-write (RMW) sequence.
- Sits between the pipeline IF/MEM stages and the RAM, which has a synchronous write and a registered read with 1-cycle latency.

Parameters:
ADDR_W, 16, word address width (RAM depth 2^ADDR_W words)
DATA_W, 32, data width; DATA_W/8 byte lanes
STARVE_MAX, 4, consecutive cycles IF may be denied while requesting before it is forced to win

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held with if_addr until if_ready
if_addr  in  ADDR_W  fetch word address
if_ready  out  1  fetch granted this cycle (combinational)
if_rvalid  out  1  fetch data valid (one-cycle pulse)
if_rdata  out  DATA_W  fetch read data
dm_req  in  1  data request; held with all dm_* until dm_ready
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data word address
dm_wdata  in  DATA_W  store data, lane-aligned
dm_be  in  DATA_W/8  store byte enables; ignored for loads
dm_ready  out  1  data request granted this cycle (combinational)
dm_rvalid  out  1  load data valid (one-cycle pulse)
dm_rdata  out  DATA_W  load read data
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM registered read data, valid the cycle after the address is sampled

Behaviour:
- FSM states: ARB, RMW.
- Reset:
  - Next state ARB; starve_cnt=0; if_rvalid=0, dm_rvalid=0; latches cleared.
  - While reset is high, ram_we=0, if_ready=0 and dm_ready=0.
  - Reset during RMW aborts the sequence; no RAM write occurs.
- ARB arbitration, evaluated each cycle:
  - If dm_req and starve_cnt<STARVE_MAX, grant DM.
  - Else if if_req, grant IF.
  - Else idle: ram_we=0, ram_addr=0.
- Grant effects: the granted requester's ready=1 in the same cycle, and ram_addr = its address in the same cycle.
- IF grant: ram_we=0; if_rvalid=1 in the next cycle, with if_rdata=ram_rdata.
- DM load: ram_we=0; dm_rvalid=1 in the next cycle, with dm_rdata=ram_rdata. Always returns the full word; byte/half extraction belongs to the pipeline.
- DM store, dm_be all ones: ram_we=1, ram_wdata=dm_wdata. Single cycle; no rvalid.
- DM store, dm_be all zeros: dm_ready=1, no RAM access (no-op). The RAM port is idle this cycle and IF is not granted.
- DM store, partial dm_be:
  - Grant cycle: ram_we=0 (read). Latch addr, wdata and be; go to RMW.
  - RMW cycle: ram_addr=latched addr, ram_we=1. ram_wdata per lane = be[i] ? wdata lane : ram_rdata lane. Return to ARB.
  - During RMW, if_ready=0 and dm_ready=0.
- Starvation counter (starve_cnt):
  - Increments (saturating at STARVE_MAX) each cycle if_req=1 and IF is not granted, including RMW cycles.
  - Clears when IF is granted or if_req=0.
- Read data: if_rdata and dm_rdata pass ram_rdata through; they are meaningful only while the matching rvalid is high. At most one rvalid is high per cycle.
- Read-after-write: a DM store followed by a load to the same address the next cycle returns the new data, because the write commits at the store cycle's edge.
- Addresses are not range-checked; the full ADDR_W space is used and wraps naturally.
- Back-to-back grants are allowed every cycle in ARB. Throughput is 1 access/cycle except partial stores (2 cycles) and be=0 stores (1 idle cycle).

Test Plan:
- Reset check: reset=1 for 2 cycles with if_req=dm_req=1 -> ready, rvalid and ram_we all 0; after release, DM is granted first.
- Basic reads: preload RAM[0x0010]=0xDEADBEEF. IF read 0x0010 alone -> if_ready in cycle t, if_rvalid=1 with if_rdata=0xDEADBEEF in t+1. Repeat via a DM load -> dm_rdata=0xDEADBEEF in t+1.
- Partial store RMW: RAM[0x0020]=0x11223344; DM store wdata=0xAABBCCDD, be=4'b0101, with if_req=1 throughout -> cycles t and t+1 produce RAM=0x11BB33DD; if_ready stays 0 in t and t+1.
- Starvation: dm_req held high with full-word stores and if_req held high -> IF granted on the 5th contending cycle (STARVE_MAX=4); counter then clears and DM wins next.
- Read-after-write and no-op store: store 0xCAFEF00D be=1111 to 0x0030, then load 0x0030 -> dm_rdata=0xCAFEF00D. A be=0000 store to 0x0030 gives dm_ready=1, ram_we=0 and leaves the data unchanged.
- Reset mid-RMW: assert reset in the RMW cycle of a partial store -> ram_we=0 and RAM word unchanged; FSM in ARB after reset.
